// File: rtl/crc8_frame_checker.sv
// CRC8 (poly 0x2F) frame checker with framing/length checks and saturating good/bad frame counters.
// Latency: frame_done and error pulses one cycle after the deciding word; no backpressure, every din_valid word is consumed.
module crc8_frame_checker #(
    parameter int WORDWIDTH = 40,
    parameter int MAXWORDS  = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORDWIDTH-1:0] din,
    input  logic                 din_valid,
    input  logic                 sof,
    input  logic                 eof,
    input  logic                 clear_cnt,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic                 crc_err,
    output logic                 proto_err,
    output logic                 len_err,
    output logic [15:0]          good_cnt,
    output logic [15:0]          bad_cnt,
    output logic [7:0]           frame_len
);

    localparam int CW = $clog2(MAXWORDS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAXWORDS);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t        state;
    logic [7:0]    rem;
    logic [CW-1:0] wcnt;

    function automatic logic [7:0] crc8_word(input logic [7:0] crc_in,
                                             input logic [WORDWIDTH-1:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc_in;
        for (int i = WORDWIDTH - 1; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h2F : 8'h00);
        end
        return c;
    endfunction

    logic [7:0] crc_new;
    logic [7:0] crc_cont;
    assign crc_new  = crc8_word(8'h00, din);
    assign crc_cont = crc8_word(rem, din);

    // Event decode shared by the FSM and the counters.
    logic in_frame, at_max, abort_p, single_p, trailer_p, over_p;
    assign in_frame  = (state == FRAME);
    assign at_max    = (wcnt == MAX_CNT);
    assign abort_p   = din_valid & sof & in_frame;
    assign single_p  = din_valid & sof & eof;
    assign trailer_p = din_valid & ~sof & eof & in_frame & ~at_max;
    assign over_p    = din_valid & ~sof & in_frame & at_max;

    logic       good_hit;
    logic [1:0] bad_add;
    assign good_hit = (single_p & (crc_new == 8'h00)) | (trailer_p & (crc_cont == 8'h00));
    assign bad_add  = {1'b0, abort_p} + {1'b0, single_p & (crc_new != 8'h00)}
                    + {1'b0, trailer_p & (crc_cont != 8'h00)} + {1'b0, over_p};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rem        <= 8'h00;
            wcnt       <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            proto_err  <= 1'b0;
            len_err    <= 1'b0;
            frame_len  <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            crc_err    <= 1'b0;
            proto_err  <= 1'b0;
            len_err    <= 1'b0;
            if (din_valid) begin
                if (sof) begin
                    if (state == FRAME) begin
                        frame_done <= 1'b1;
                        frame_ok   <= 1'b0;
                        proto_err  <= 1'b1;
                        frame_len  <= 8'(wcnt);
                    end
                    rem <= crc_new;
                    // A combined sof+eof word reports its own result, overriding the abort result.
                    if (eof) begin
                        frame_done <= 1'b1;
                        frame_ok   <= (crc_new == 8'h00);
                        crc_err    <= (crc_new != 8'h00);
                        frame_len  <= 8'd1;
                        state      <= IDLE;
                        wcnt       <= '0;
                    end else begin
                        state <= FRAME;
                        wcnt  <= CW'(1);
                    end
                end else if (state == FRAME) begin
                    if (at_max) begin
                        frame_done <= 1'b1;
                        frame_ok   <= 1'b0;
                        len_err    <= 1'b1;
                        frame_len  <= 8'(wcnt);
                        state      <= IDLE;
                        wcnt       <= '0;
                    end else begin
                        rem  <= crc_cont;
                        wcnt <= wcnt + 1'b1;
                        if (eof) begin
                            frame_done <= 1'b1;
                            frame_ok   <= (crc_cont == 8'h00);
                            crc_err    <= (crc_cont != 8'h00);
                            frame_len  <= 8'(wcnt + 1'b1);
                            state      <= IDLE;
                            wcnt       <= '0;
                        end
                    end
                end else if (eof) begin
                    proto_err <= 1'b1;
                end
            end
        end
    end

    logic [16:0] good_sum;
    logic [16:0] bad_sum;
    assign good_sum = {1'b0, good_cnt} + {16'd0, good_hit};
    assign bad_sum  = {1'b0, bad_cnt} + {15'd0, bad_add};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_cnt <= 16'd0;
            bad_cnt  <= 16'd0;
        end else if (clear_cnt) begin
            good_cnt <= 16'd0;
            bad_cnt  <= 16'd0;
        end else begin
            good_cnt <= good_sum[16] ? 16'hFFFF : good_sum[15:0];
            bad_cnt  <= bad_sum[16]  ? 16'hFFFF : bad_sum[15:0];
        end
    end

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Directed and table-driven bench for crc8_frame_checker with a bytewise CRC8 reference.
module tb_crc8_frame_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] din;
    logic        din_valid, sof, eof, clear_cnt;
    logic        frame_done, frame_ok, crc_err, proto_err, len_err;
    logic [15:0] good_cnt, bad_cnt;
    logic [7:0]  frame_len;

    int checks = 0;
    int errors = 0;
    int exp_good = 0;
    int exp_bad = 0;

    crc8_frame_checker #(.WORDWIDTH(40), .MAXWORDS(255)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sof(sof), .eof(eof),
        .clear_cnt(clear_cnt), .frame_done(frame_done), .frame_ok(frame_ok), .crc_err(crc_err),
        .proto_err(proto_err), .len_err(len_err), .good_cnt(good_cnt), .bad_cnt(bad_cnt),
        .frame_len(frame_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld, s, e, clr;
        logic [39:0] d;
        logic        done, ok, ce, pe, le;
        logic [7:0]  flen;
        logic [15:0] good, bad;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic vld, s, e, clr, input logic [39:0] d,
                                input logic done, ok, ce, pe, le, input logic [7:0] flen,
                                input logic [15:0] good, bad);
        vec_t v;
        v.vld = vld; v.s = s; v.e = e; v.clr = clr; v.d = d;
        v.done = done; v.ok = ok; v.ce = ce; v.pe = pe; v.le = le;
        v.flen = flen; v.good = good; v.bad = bad;
        return v;
    endfunction

    // Reference CRC8: one byte at a time, most significant byte first.
    function automatic logic [7:0] crc_bytes(input logic [7:0] c_in, input logic [39:0] d, input int nb);
        logic [7:0] c;
        c = c_in;
        for (int b = nb - 1; b >= 0; b--) begin
            c = c ^ d[8*b +: 8];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h2F) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [39:0] trailer(input logic [7:0] c, input logic [31:0] u);
        return {u, crc_bytes(c, {8'h00, u}, 4)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_done, e_ok, e_ce, e_pe, e_le,
                           input logic [7:0] e_flen, input logic [15:0] e_good, e_bad);
        chk({tag, " frame_done"}, frame_done, e_done);
        chk({tag, " frame_ok"}, frame_ok, e_ok);
        chk({tag, " crc_err"}, crc_err, e_ce);
        chk({tag, " proto_err"}, proto_err, e_pe);
        chk({tag, " len_err"}, len_err, e_le);
        chk({tag, " good_cnt"}, good_cnt, e_good);
        chk({tag, " bad_cnt"}, bad_cnt, e_bad);
        if (e_flen != 8'd0) chk({tag, " frame_len"}, frame_len, e_flen);
    endtask

    task automatic cycle(input logic v, s, e, c, input logic [39:0] d);
        din_valid = v; sof = s; eof = e; clear_cnt = c; din = d;
        @(posedge clk); #1;
        din_valid = 1'b0; sof = 1'b0; eof = 1'b0; clear_cnt = 1'b0; din = '0;
    endtask

    logic [39:0] wa, wb, wc, wd, we, wf, t1, t2, t3, ws, ws_bad;
    logic [39:0] w[10];
    logic [7:0]  c;

    initial begin
        reset = 1'b1; din = '0; din_valid = 1'b0; sof = 1'b0; eof = 1'b0; clear_cnt = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_all("reset", 0, 0, 0, 0, 0, 8'd0, 16'd0, 16'd0);
        chk("reset frame_len", frame_len, 8'd0);
        reset = 1'b0;

        wa = 40'h1122334455; wb = 40'hA5A50F0F3C; wc = 40'h0123456789; wd = 40'hFEDCBA9876;
        we = 40'h5555AAAA11; wf = 40'h00FF00FF00;
        t1 = trailer(crc_bytes(crc_bytes(8'h00, wc, 5), wd, 5), 32'hCAFEF00D);
        t2 = trailer(crc_bytes(crc_bytes(8'h00, we, 5), wf, 5), 32'h13579BDF);
        t3 = trailer(crc_bytes(8'h00, wa, 5), 32'h0BADC0DE);
        ws = trailer(8'h00, 32'hDEADBEEF);
        ws_bad = ws ^ 40'h1;

        //                vld sof eof clr din          done ok ce pe le flen good bad
        vecs.push_back(mk(1, 1, 0, 0, 40'h0,           0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 40'h0,           1, 1, 0, 0, 0, 2, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 40'h0,           0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 40'h1,           1, 0, 1, 0, 0, 2, 1, 1));
        vecs.push_back(mk(1, 0, 1, 0, wa,              0, 0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, wb,              0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, wa,              0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, wb,              0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, wc,              1, 0, 0, 1, 0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 1, 0, wa,              0, 0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 0, 0, 0, wd,              0, 0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 0, 1, 0, t1,              1, 1, 0, 0, 0, 3, 2, 2));
        vecs.push_back(mk(1, 1, 1, 0, ws,              1, 1, 0, 0, 0, 1, 3, 2));
        vecs.push_back(mk(1, 1, 1, 0, ws_bad,          1, 0, 1, 0, 0, 1, 3, 3));
        vecs.push_back(mk(1, 1, 0, 0, we,              0, 0, 0, 0, 0, 0, 3, 3));
        vecs.push_back(mk(0, 0, 0, 0, 40'h0,           0, 0, 0, 0, 0, 0, 3, 3));
        vecs.push_back(mk(1, 0, 0, 0, wf,              0, 0, 0, 0, 0, 0, 3, 3));
        vecs.push_back(mk(0, 0, 1, 0, 40'h0,           0, 0, 0, 0, 0, 0, 3, 3));
        vecs.push_back(mk(1, 0, 1, 0, t2,              1, 1, 0, 0, 0, 3, 4, 3));
        vecs.push_back(mk(1, 1, 0, 0, wa,              0, 1, 0, 0, 0, 0, 4, 3));
        vecs.push_back(mk(1, 0, 1, 1, t3,              1, 1, 0, 0, 0, 2, 0, 0));

        foreach (vecs[i]) begin
            cycle(vecs[i].vld, vecs[i].s, vecs[i].e, vecs[i].clr, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].done, vecs[i].ok, vecs[i].ce, vecs[i].pe,
                    vecs[i].le, vecs[i].flen, vecs[i].good, vecs[i].bad);
        end
        exp_good = 0; exp_bad = 0;

        // Maximum-length frame of 255 words is accepted.
        w[0] = 40'({$urandom(), $urandom()});
        c = crc_bytes(8'h00, w[0], 5);
        cycle(1, 1, 0, 0, w[0]);
        for (int j = 0; j < 253; j++) begin
            w[1] = 40'({$urandom(), $urandom()});
            c = crc_bytes(c, w[1], 5);
            cycle(1, 0, 0, 0, w[1]);
        end
        cycle(1, 0, 1, 0, trailer(c, $urandom()));
        exp_good++;
        chk_all("maxlen", 1, 1, 0, 0, 0, 8'd255, 16'(exp_good), 16'(exp_bad));

        // 256th word overflows the frame.
        cycle(1, 1, 0, 0, wa);
        for (int j = 0; j < 254; j++) cycle(1, 0, 0, 0, 40'({$urandom(), $urandom()}));
        cycle(1, 0, 0, 0, wb);
        exp_bad++;
        chk_all("overflow", 1, 0, 0, 0, 1, 8'd0, 16'(exp_good), 16'(exp_bad));
        cycle(1, 0, 1, 0, wc);
        chk_all("after_overflow", 0, 0, 0, 1, 0, 8'd0, 16'(exp_good), 16'(exp_bad));

        // Random frames with one flipped bit must all be rejected.
        for (int f = 0; f < 1000; f++) begin
            int n, pos;
            n = $urandom_range(2, 10);
            c = 8'h00;
            for (int j = 0; j < n - 1; j++) begin
                w[j] = 40'({$urandom(), $urandom()});
                c = crc_bytes(c, w[j], 5);
            end
            w[n-1] = trailer(c, $urandom());
            pos = $urandom_range(0, n * 40 - 1);
            w[pos/40][pos%40] = ~w[pos/40][pos%40];
            for (int j = 0; j < n; j++) begin
                if (j > 0 && $urandom_range(0, 3) == 0) cycle(0, 0, 0, 0, 40'h0);
                cycle(1, j == 0, j == n - 1, 0, w[j]);
            end
            exp_bad++;
            chk_all($sformatf("rand%0d", f), 1, 0, 1, 0, 0, 8'(n), 16'(exp_good), 16'(exp_bad));
        end

        // Saturation of good_cnt.
        cycle(0, 0, 0, 1, 40'h0);
        chk_all("clear", 0, 0, 0, 0, 0, 8'd0, 16'd0, 16'd0);
        for (int j = 0; j < 65535; j++) cycle(1, 1, 1, 0, 40'h0);
        chk("sat good_cnt", good_cnt, 16'hFFFF);
        cycle(1, 1, 1, 0, ws);
        chk_all("sat_hold", 1, 1, 0, 0, 0, 8'd1, 16'hFFFF, 16'd0);

        // Reset mid-frame drops the frame; the next frame is processed normally.
        cycle(1, 1, 0, 0, wa);
        cycle(1, 0, 0, 0, wb);
        #2 reset = 1'b1;
        #1;
        chk_all("mid_reset", 0, 0, 0, 0, 0, 8'd0, 16'd0, 16'd0);
        chk("mid_reset frame_len", frame_len, 8'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        cycle(1, 1, 0, 0, wa);
        cycle(1, 0, 1, 0, t3);
        chk_all("post_reset", 1, 1, 0, 0, 0, 8'd2, 16'd1, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc8_frame_checker.md
CRC8_FRAME_CHECKER -- requirements
Module: crc8_frame_checker

Interface
REQ-001 SHALL have parameter WORDWIDTH, default 40, input word width in bits; must be a multiple of 8 and at least 16.
REQ-002 SHALL have parameter MAXWORDS, default 255, maximum words per frame, header and trailer included.
REQ-003 SHALL have a single clock: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 din  input  WORDWIDTH  received word; the trailer word carries the CRC byte in din[7:0].
REQ-007 din_valid  input  1  din is accepted this cycle.
REQ-008 sof  input  1  first word of frame; qualified by din_valid.
REQ-009 eof  input  1  last (trailer) word of frame; qualified by din_valid.
REQ-010 clear_cnt  input  1  synchronous clear of both frame counters.
REQ-011 frame_done  output  1  one-cycle pulse when a frame completes or is aborted.
REQ-012 frame_ok  output  1  result of the last frame; valid while frame_done is high and held until the next frame_done.
REQ-013 crc_err  output  1  one-cycle pulse on a CRC residue mismatch.
REQ-014 proto_err  output  1  one-cycle pulse on a framing violation.
REQ-015 len_err  output  1  one-cycle pulse on a frame longer than MAXWORDS.
REQ-016 good_cnt  output  16  saturating count of good frames.
REQ-017 bad_cnt  output  16  saturating count of bad or aborted frames.
REQ-018 frame_len  output  8  word count of the last completed frame; valid with frame_done.

Function
REQ-019 The CRC8 algorithm SHALL use polynomial 0x2F, initial value 0x00, MSB of din first, no reflection and no final XOR.
REQ-020 The CRC SHALL be computed over every accepted word of a frame, including all WORDWIDTH bits of the trailer.
REQ-021 A frame SHALL be good if and only if the running remainder after the trailer word equals 0x00.
REQ-022 The checker SHALL implement an FSM with states IDLE and FRAME.
REQ-023 In IDLE, din_valid with sof SHALL load the remainder with CRC(0x00, din), set the word count to 1 and move to FRAME.
REQ-024 In IDLE, din_valid with sof and eof together SHALL be treated as a single-word frame and evaluated as in REQ-026; the FSM stays in IDLE.
REQ-025 In FRAME, din_valid without sof or eof SHALL update the remainder and increment the word count.
REQ-026 In FRAME, din_valid with eof SHALL complete the frame:
- frame_done pulses one cycle after the trailer is accepted (latency 1);
- frame_ok is set to (remainder==0);
- crc_err pulses if the remainder is non-zero;
- the FSM returns to IDLE.
REQ-027 In FRAME, din_valid with sof SHALL abort the current frame:
- frame_done=1, frame_ok=0, proto_err=1, bad_cnt increments;
- the new word starts a new frame as in REQ-023, or as in REQ-024 if eof is also set.
REQ-028 In IDLE, din_valid with eof and without sof SHALL pulse proto_err only; no counter or frame_done change occurs.
REQ-029 In IDLE, din_valid without sof or eof SHALL be ignored silently.
REQ-030 Accepting a word that would make the count exceed MAXWORDS SHALL abort the frame:
- frame_done=1, frame_ok=0, len_err=1, bad_cnt increments;
- the FSM returns to IDLE and that word is discarded.
REQ-031 Cycles with din_valid=0 SHALL hold all state; sof and eof are ignored in those cycles.
REQ-032 good_cnt and bad_cnt SHALL saturate at 0xFFFF.
REQ-033 When clear_cnt coincides with an increment, the counter SHALL result in 0.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 Reset SHALL asynchronously set:
- FSM to IDLE, remainder to 0x00, word count to 0;
- frame_done, frame_ok, crc_err, proto_err and len_err to 0;
- good_cnt, bad_cnt and frame_len to 0.
REQ-036 A frame in progress when reset asserts SHALL be dropped without counting; the first valid word after release is processed normally.

Verification
REQ-037 Zero frame: sof word 0x0000000000 followed by eof word 0x0000000000 -> frame_done one cycle later, frame_ok=1, frame_len=2, good_cnt=1.
REQ-038 Corrupt CRC: same frame with eof word 0x0000000001 -> frame_ok=0, crc_err pulse, bad_cnt=1; also 1000 random frames of 2-10 words against the golden CRC8 model, each with a random single-bit flip, all flagged bad.
REQ-039 Framing: eof in IDLE -> proto_err pulse with counters unchanged; sof mid-frame -> abort pulse, bad_cnt+1, and the following frame checks good.
REQ-040 Length: MAXWORDS=255 frame -> good; 256th word without eof -> len_err, bad_cnt+1, FSM back in IDLE.
REQ-041 Single-word frame: sof=eof=1 on one 40-bit word with a valid CRC byte -> frame_ok=1, frame_len=1; din_valid gaps inserted mid-frame do not change the result.
REQ-042 Counters and reset: preload good_cnt to 0xFFFF -> stays at 0xFFFF on a further good frame; clear_cnt asserted with frame_done -> counter reads 0; reset asserted mid-frame -> all outputs 0 and the next frame is processed correctly.
